// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the XOR parity accumulator.
//   frame_state_t : frame FSM state (IDLE = no frame open, ACCUM = frame open)
//   count_width() : width needed to hold a word count of 0..max_words
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } frame_state_t;

    // A count must represent MAX_WORDS itself, hence the +1.
    function automatic int count_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_reduce_tree.sv
// -----------------------------------------------------------------------------
// xor_reduce_tree
// Purely combinational WIDTH-to-1 XOR reduction.
// The tree is built by splitting the vector in half and recursing, so the
// result is a balanced tree of two-input XORs of depth ceil(log2(WIDTH)).
// Ports:
//   data   in  WIDTH  vector to reduce
//   parity out 1      XOR of all bits of data
// -----------------------------------------------------------------------------
module xor_reduce_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign parity = data[0];
        end else begin : g_split
            localparam int LO_W = WIDTH / 2;
            localparam int HI_W = WIDTH - LO_W;

            logic lo_parity;
            logic hi_parity;

            xor_reduce_tree #(.WIDTH(LO_W)) u_lo (
                .data   (data[LO_W-1:0]),
                .parity (lo_parity)
            );

            xor_reduce_tree #(.WIDTH(HI_W)) u_hi (
                .data   (data[WIDTH-1:LO_W]),
                .parity (hi_parity)
            );

            assign parity = lo_parity ^ hi_parity;
        end
    endgenerate

endmodule

// File: rtl/xor_parity_accum.sv
// -----------------------------------------------------------------------------
// xor_parity_accum
// Accumulates a stream of WIDTH-bit words into column parity (bitwise XOR of
// all words) and row parity (XOR of all bits) per frame, with even/odd sense
// chosen on the first beat of each frame. A frame closes on in_last or when
// MAX_WORDS words have been taken; the result is held in a registered
// valid/ready output stage.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   input word stream
//   odd_mode                            1 = odd parity (first beat of frame)
//   out_valid/out_ready                 result handshake
//   out_col_parity                      column parity of the frame
//   out_row_parity                      row parity of the frame
//   out_count                           words in the frame (1..MAX_WORDS)
//   out_overflow                        frame closed by MAX_WORDS, not in_last
// -----------------------------------------------------------------------------
module xor_parity_accum
    import parity_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int CW        = count_width(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_col_parity,
    output logic             out_row_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_WORDS);

    frame_state_t     state_reg, state_next;
    logic [WIDTH-1:0] acc_reg,   acc_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;
    logic             mode_reg,  mode_next;

    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] col_reg;
    logic             row_reg;
    logic [CW-1:0]    count_reg;
    logic             overflow_reg;

    logic             beat;
    logic             close;
    logic [CW-1:0]    cnt_plus;
    logic [WIDTH-1:0] acc_fold;
    logic             fold_parity;
    logic             frame_mode;

    // The output stage frees up in the same cycle the consumer takes it, so
    // a stalled producer resumes without a bubble.
    assign in_ready = !out_valid_reg || out_ready;
    assign beat     = in_valid && in_ready;

    // acc and cnt are zero while IDLE, so the fold works for first beats too.
    assign cnt_plus   = cnt_reg + 1'b1;
    assign acc_fold   = acc_reg ^ in_data;
    assign frame_mode = (state_reg == IDLE) ? odd_mode : mode_reg;
    assign close      = beat && (in_last || (cnt_plus == MAX_COUNT));

    xor_reduce_tree #(.WIDTH(WIDTH)) u_row_tree (
        .data   (acc_fold),
        .parity (fold_parity)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;

        if (beat) begin
            if (close) begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                state_next = ACCUM;
                acc_next   = acc_fold;
                cnt_next   = cnt_plus;
                if (state_reg == IDLE) begin
                    mode_next = odd_mode;
                end
            end
        end
    end

    // A closing beat wins over a transfer: the new result replaces the old
    // one and out_valid stays high.
    always_comb begin
        out_valid_next = out_valid_reg;
        if (close) begin
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            mode_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            col_reg       <= '0;
            row_reg       <= 1'b0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            mode_reg      <= mode_next;
            out_valid_reg <= out_valid_next;
            if (close) begin
                col_reg      <= acc_fold ^ {WIDTH{frame_mode}};
                row_reg      <= fold_parity ^ frame_mode;
                count_reg    <= cnt_plus;
                overflow_reg <= !in_last;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_col_parity = col_reg;
    assign out_row_parity = row_reg;
    assign out_count      = count_reg;
    assign out_overflow   = overflow_reg;

endmodule

// File: tb/tb_xor_parity_accum.sv
module tb_xor_parity_accum;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CW        = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_col_parity;
    logic             out_row_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] col;
        logic             row;
        logic [CW-1:0]    cnt;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    xor_parity_accum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .odd_mode       (odd_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_col_parity (out_col_parity),
        .out_row_parity (out_row_parity),
        .out_count      (out_count),
        .out_overflow   (out_overflow)
    );

    // Scoreboard: every result transfer pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got col=%h row=%b cnt=%0d ovf=%b, none expected",
                         out_col_parity, out_row_parity, out_count, out_overflow);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_col_parity, out_row_parity, out_count, out_overflow} !==
                    {e.col, e.row, e.cnt, e.ovf}) begin
                    errors++;
                    $display("FAIL result: got col=%h row=%b cnt=%0d ovf=%b, want col=%h row=%b cnt=%0d ovf=%b",
                             out_col_parity, out_row_parity, out_count, out_overflow,
                             e.col, e.row, e.cnt, e.ovf);
                end else begin
                    $display("RESULT col=%h row=%b cnt=%0d ovf=%b ok",
                             out_col_parity, out_row_parity, out_count, out_overflow);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [WIDTH-1:0] col, input logic row,
                            input logic [CW-1:0] cnt, input logic ovf);
        exp_t e;
        e.col = col; e.row = row; e.cnt = cnt; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input logic mode);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = mode;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, want 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("BEAT data=%h last=%b mode=%b", d, last, mode);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        odd_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_col_parity, out_row_parity, out_count, out_overflow, in_ready} !==
            {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b col=%h row=%b cnt=%0d ovf=%b rdy=%b, want 0/00/0/0/0/1",
                     out_valid, out_col_parity, out_row_parity, out_count, out_overflow, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_exp(8'hA5, 1'b0, 3'd1, 1'b0);
        send_beat(8'hA5, 1'b1, 1'b0);
        // Latency: result visible right after the accepting edge.
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: out_valid=%b, want 1", out_valid);
        end
        drain("single");
    endtask

    task automatic test_multi_odd();
        out_ready = 1'b1;
        // Mode is sampled on the first beat only; later beats carry 0.
        push_exp(8'hF8, 1'b0, 3'd3, 1'b0);
        send_beat(8'h01, 1'b0, 1'b1);
        send_beat(8'h02, 1'b0, 1'b0);
        send_beat(8'h04, 1'b1, 1'b0);
        drain("multi_odd");
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        push_exp(8'h00, 1'b0, 3'd4, 1'b1);
        push_exp(8'h10, 1'b1, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'h10, 1'b1, 1'b0);
        drain("overflow");
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        push_exp(8'h5A, 1'b0, 3'd1, 1'b0);
        send_beat(8'h5A, 1'b1, 1'b0);
        push_exp(8'h31, 1'b1, 3'd1, 1'b0);
        in_valid = 1'b1; in_data = 8'h31; in_last = 1'b1; odd_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_col_parity, out_row_parity, out_count, out_overflow} !==
                {1'b0, 1'b1, 8'h5A, 1'b0, 3'd1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got rdy=%b valid=%b col=%h row=%b cnt=%0d ovf=%b, want 0/1/5a/0/1/0",
                         c, in_ready, out_valid, out_col_parity, out_row_parity, out_count, out_overflow);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_bubble: out_valid=%b, want 1", out_valid);
        end
        drain("stall");
    endtask

    task automatic test_midframe_reset();
        out_ready = 1'b1;
        send_beat(8'h11, 1'b0, 1'b1);
        send_beat(8'h22, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_col_parity, out_row_parity, out_count, out_overflow, in_ready} !==
            {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midframe_reset: got valid=%b col=%h row=%b cnt=%0d ovf=%b rdy=%b, want 0/00/0/0/0/1",
                     out_valid, out_col_parity, out_row_parity, out_count, out_overflow, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(8'h3C, 1'b0, 3'd1, 1'b0);
        send_beat(8'h3C, 1'b1, 1'b0);
        drain("midframe_reset");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w [3];
        w = '{8'h01, 8'h03, 8'h07};
        out_ready = 1'b1;
        push_exp(8'h01, 1'b1, 3'd1, 1'b0);
        push_exp(8'h03, 1'b0, 3'd1, 1'b0);
        push_exp(8'h07, 1'b1, 3'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = w[k]; in_last = 1'b1; odd_mode = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || (k > 0 && out_valid !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_cycle %0d: in_ready=%b out_valid=%b, want 1/%b",
                         k, in_ready, out_valid, (k > 0));
            end
            @(posedge clk);
            #1;
            $display("BEAT data=%h last=1 mode=0", w[k]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third: out_valid=%b, want 1", out_valid);
        end
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_odd();
        test_overflow();
        test_stall();
        test_midframe_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
